division_unit: RTL and testbench

DIVISION_UNIT -- requirements
Module: division_unit

---
 rtl/div_pkg.sv | 26 ++
 rtl/div_step.sv | 21 ++
 rtl/division_unit.sv | 148 ++++++++++++++
 tb/tb_division_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared encodings for the integer divide unit.
// Operation codes and FSM states used by the decoder and ALU mux.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } state_e;

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it fits.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic            in_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic            q_bit
);

  logic [XLEN+1:0] partial;
  logic [XLEN+1:0] diff;

  assign partial  = {rem, in_bit};
  assign diff     = partial - {2'b00, divisor};
  assign q_bit    = ~diff[XLEN+1];
  assign rem_next = q_bit ? diff[XLEN:0] : partial[XLEN:0];

endmodule

// File: rtl/division_unit.sv
// Multi-cycle RV32M-style divider: DIV/DIVU/REM/REMU.
// Special cases (x/0, MIN/-1) bypass the iteration and finish in FIN.
module division_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            En,
  input  logic [1:0]      operation_i,
  input  logic [XLEN-1:0] Dividend_i,
  input  logic [XLEN-1:0] Divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_e state, state_next;

  logic            rem_op;
  logic            sign_a;
  logic            sign_b;
  logic            special;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] quo;
  logic [XLEN:0]   rem;
  logic [CW-1:0]   cnt;

  op_e             op_in;
  logic            signed_in;
  logic            sa_in;
  logic            sb_in;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            ovf;
  logic            special_in;
  logic [XLEN-1:0] spec_val;

  logic [XLEN:0]   rem_next;
  logic            q_bit;
  logic            last;
  logic [XLEN-1:0] final_val;

  assign op_in     = op_e'(operation_i);
  assign signed_in = is_signed_op(op_in);
  assign sa_in     = signed_in & Dividend_i[XLEN-1];
  assign sb_in     = signed_in & Divisor_i[XLEN-1];
  // MIN negates to itself, which reads correctly as an unsigned magnitude
  assign mag_a     = sa_in ? -Dividend_i : Dividend_i;
  assign mag_b     = sb_in ? -Divisor_i : Divisor_i;

  assign div_zero  = (Divisor_i == '0);
  assign ovf       = signed_in && (Dividend_i == MIN_VAL)
                     && (&Divisor_i);
  assign special_in = div_zero | ovf;

  always_comb begin
    spec_val = '0;
    if (div_zero)
      spec_val = is_rem_op(op_in) ? Dividend_i : '1;
    else
      spec_val = is_rem_op(op_in) ? '0 : MIN_VAL;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .in_bit   (quo[XLEN-1]),
    .divisor  (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign last = (cnt == CW'(XLEN - 1));

  always_comb begin
    final_val = quo;
    if (!special) begin
      if (rem_op)
        final_val = sign_a ? -rem[XLEN-1:0] : rem[XLEN-1:0];
      else
        final_val = (sign_a ^ sign_b) ? -quo : quo;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (En) state_next = special_in ? FIN : CALC;
      CALC: if (last) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      rem_op   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      special  <= 1'b0;
      dvs      <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      result_o <= '0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (En) begin
            rem_op  <= is_rem_op(op_in);
            sign_a  <= sa_in;
            sign_b  <= sb_in;
            special <= special_in;
            dvs     <= mag_b;
            quo     <= special_in ? spec_val : mag_a;
            rem     <= '0;
            cnt     <= '0;
          end
        end
        CALC: begin
          rem <= rem_next;
          quo <= {quo[XLEN-2:0], q_bit};
          cnt <= cnt + CW'(1);
        end
        FIN: begin
          result_o <= final_val;
          done_o   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_division_unit.sv
// Directed bench for division_unit with a cycle-level reference model
// tracking completion time and expected result.
module tb_division_unit;

  logic        CLK = 1'b0;
  logic        rst;
  logic        En;
  logic [1:0]  operation_i;
  logic [31:0] Dividend_i;
  logic [31:0] Divisor_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  always #5 CLK = ~CLK;

  division_unit #(.XLEN(32)) dut (
    .CLK         (CLK),
    .rst         (rst),
    .En          (En),
    .operation_i (operation_i),
    .Dividend_i  (Dividend_i),
    .Divisor_i   (Divisor_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic is_special(input logic [1:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      DIV:     return 32'(sa / sb);
      DIVU:    return a / b;
      REM:     return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // Model: edges remaining until completion, plus pending result
  int          left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] pend = '0;

  always @(posedge CLK) begin
    if (rst) begin
      left   <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
    end else if (left > 1) begin
      left   <= left - 1;
      m_done <= 1'b0;
    end else if (left == 1) begin
      left   <= 0;
      m_done <= 1'b1;
      m_res  <= pend;
    end else begin
      m_done <= 1'b0;
      if (En) begin
        left <= is_special(operation_i, Dividend_i, Divisor_i) ? 1 : 33;
        pend <= ref_div(operation_i, Dividend_i, Divisor_i);
      end
    end
  end

  always @(negedge CLK) begin
    chk("busy", 32'(busy_o), 32'(left != 0));
    chk("done", 32'(done_o), 32'(m_done));
    chk("result", result_o, m_res);
  end

  task automatic start(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    operation_i = op;
    Dividend_i  = a;
    Divisor_i   = b;
    En          = 1'b1;
    @(negedge CLK);
    En = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat, input logic [31:0] exp,
                           input string name);
    int lat;
    lat = 0;
    while (!done_o && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    chk({"lat ", name}, 32'(lat), 32'(exp_lat));
    chk(name, result_o, exp);
  endtask

  initial begin
    rst = 1'b1;
    En = 1'b0;
    operation_i = DIV;
    Dividend_i = '0;
    Divisor_i = '0;
    repeat (2) @(negedge CLK);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst result", result_o, 32'd0);
    rst = 1'b0;
    @(negedge CLK);

    start(DIV, 32'd100, 32'd7);
    wait_done(33, 32'd14, "div 100/7");
    start(REM, 32'hFFFF_FF9C, 32'd7);
    wait_done(33, 32'hFFFF_FFFE, "rem -100/7");
    start(DIV, 32'hFFFF_FF9C, 32'd7);
    wait_done(33, 32'hFFFF_FFF2, "div -100/7");
    start(DIVU, 32'hFFFF_FFFF, 32'd2);
    wait_done(33, 32'h7FFF_FFFF, "divu max/2");
    start(REMU, 32'hFFFF_FFFF, 32'd2);
    wait_done(33, 32'd1, "remu max/2");
    start(DIV, 32'd5, 32'd0);
    wait_done(1, 32'hFFFF_FFFF, "div 5/0");
    start(REMU, 32'd5, 32'd0);
    wait_done(1, 32'd5, "remu 5/0");
    start(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, 32'h8000_0000, "div ovf");
    start(REM, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, 32'd0, "rem ovf");
    start(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(33, 32'hFFFF_FFFD, "div -7/2");
    start(REM, 32'd7, 32'hFFFF_FFFE);
    wait_done(33, 32'd1, "rem 7/-2");
    start(REM, 32'h8000_0000, 32'd3);
    wait_done(33, 32'hFFFF_FFFE, "rem min/3");
    start(DIV, 32'h8000_0000, 32'd2);
    wait_done(33, 32'hC000_0000, "div min/2");
    start(DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(33, 32'd0, "divu min/max");
    start(REMU, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(33, 32'h8000_0000, "remu min/max");

    // Reset at cycle 10 of a DIV, with En asserted alongside
    start(DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge CLK);
    rst = 1'b1;
    En = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    En = 1'b0;
    chk("mid rst busy", 32'(busy_o), 32'd0);
    chk("mid rst done", 32'(done_o), 32'd0);
    chk("mid rst result", result_o, 32'd0);
    repeat (40) @(negedge CLK);
    chk("no done after rst", result_o, 32'd0);

    // En while busy is ignored
    start(DIVU, 32'd200, 32'd10);
    repeat (5) @(negedge CLK);
    start(DIV, 32'd9, 32'd3);
    wait_done(27, 32'd20, "busy en ignored");
    repeat (40) @(negedge CLK);
    chk("first result held", result_o, 32'd20);

    // Back-to-back: new En in the done cycle
    start(DIV, 32'd100, 32'd7);
    wait_done(33, 32'd14, "b2b first");
    start(REMU, 32'd100, 32'd7);
    wait_done(33, 32'd2, "b2b second");
    repeat (3) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
